// File: rtl/motor602_pkg.sv
// Shared motor602 definitions: ramp FSM state encodings, the period width and
// saturating period arithmetic helpers.
package motor602_pkg;

    localparam int unsigned PERIOD_W = 22;

    typedef logic [PERIOD_W-1:0] period_t;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAccel = 3'd1,
        StRun   = 3'd2,
        StDecel = 3'd3,
        StStop  = 3'd4
    } ramp_state_e;

    // a - b, never going below lo (a is assumed >= lo)
    function automatic period_t sat_sub(period_t a, period_t b, period_t lo);
        if (a > lo && (a - lo) > b) begin
            return a - b;
        end
        return lo;
    endfunction

    // a + b, never going above hi (a is assumed <= hi)
    function automatic period_t sat_add(period_t a, period_t b, period_t hi);
        if (a < hi && (hi - a) > b) begin
            return a + b;
        end
        return hi;
    endfunction

endpackage

// File: rtl/m3_ramp_wdog.sv
// Stall watchdog for the ramp controller: counts run-enabled cycles between step
// boundaries and raises a sticky fault once the limit is reached.
module m3_ramp_wdog
    import motor602_pkg::*;
#(
    parameter logic [PERIOD_W:0] LIMIT = 23'd800000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_trip,
    output logic o_fault
);

    logic [PERIOD_W:0] r_cnt;
    logic [PERIOD_W:0] w_cnt_d;
    logic              r_fault;
    logic              w_trip;

    assign w_trip  = (r_cnt >= LIMIT);
    assign o_trip  = w_trip;
    assign o_fault = r_fault;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_en && r_cnt < LIMIT) begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_d;
            r_fault <= r_fault | w_trip;
        end
    end

endmodule

// File: rtl/m3_ramp_ctrl.sv
// Stepper speed-ramp controller: accelerates/decelerates the step period toward a
// commanded target on step boundaries. Optional stall watchdog: M3_RAMP_WDOG_EN.
module m3_ramp_ctrl
    import motor602_pkg::*;
#(
    parameter period_t PERIOD_SLOW = 22'd400000,
    parameter period_t PERIOD_FAST = 22'd20000,
    parameter period_t RAMP_DELTA  = 22'd2000,
    parameter period_t SPEED_DELTA = 22'd10000
) (
    input  logic                clkI,
    input  logic                rstI,
    input  logic                startI,
    input  logic                forceStopI,
    input  logic                speedINCi,
    input  logic                speedDECi,
    input  logic                stepDoneI,
    output logic                m3startO,
    output logic [PERIOD_W-1:0] periodO,
    output logic [2:0]          stateO,
    output logic                busyO,
    output logic                faultO
);

    ramp_state_e r_state, w_state_d;
    period_t     r_period, w_period_d;
    period_t     r_target, w_target_d;
    logic        r_m3start, w_m3start_d;
    period_t     w_tgt_cmd;
    period_t     w_step;
    period_t     w_stop_step;
    logic        w_trip;
    logic        w_fault;

`ifdef M3_RAMP_WDOG_EN
    localparam logic [PERIOD_W:0] WDOG_LIMIT = {PERIOD_SLOW, 1'b0};

    m3_ramp_wdog #(
        .LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .i_clk  (clkI),
        .i_rst  (rstI),
        .i_clr  (stepDoneI || (r_state == StIdle)),
        .i_en   (r_m3start),
        .o_trip (w_trip),
        .o_fault(w_fault)
    );
`else
    assign w_trip  = 1'b0;
    assign w_fault = 1'b0;
`endif

    // Speed commands resolve first so a coincident ramp step chases the new target.
    always_comb begin
        w_tgt_cmd = r_target;
        if (speedINCi && !speedDECi) begin
            w_tgt_cmd = sat_sub(r_target, SPEED_DELTA, PERIOD_FAST);
        end else if (speedDECi && !speedINCi) begin
            w_tgt_cmd = sat_add(r_target, SPEED_DELTA, PERIOD_SLOW);
        end
    end

    always_comb begin
        w_step = r_period;
        if (stepDoneI) begin
            if (r_period > w_tgt_cmd) begin
                w_step = sat_sub(r_period, RAMP_DELTA, w_tgt_cmd);
            end else begin
                w_step = sat_add(r_period, RAMP_DELTA, w_tgt_cmd);
            end
        end
    end

    assign w_stop_step = sat_add(r_period, RAMP_DELTA, PERIOD_SLOW);

    always_comb begin
        w_state_d  = r_state;
        w_period_d = r_period;
        w_target_d = r_target;
        if (forceStopI || w_trip) begin
            w_state_d  = StIdle;
            w_period_d = PERIOD_SLOW;
            w_target_d = PERIOD_SLOW;
        end else begin
            case (r_state)
                StIdle: begin
                    w_period_d = PERIOD_SLOW;
                    w_target_d = PERIOD_SLOW;
                    if (startI && !w_fault) begin
                        w_state_d  = StAccel;
                        w_target_d = sat_sub(PERIOD_SLOW, SPEED_DELTA, PERIOD_FAST);
                    end
                end
                StAccel, StRun, StDecel: begin
                    if (!startI) begin
                        w_state_d  = StStop;
                        w_target_d = PERIOD_SLOW;
                    end else begin
                        w_target_d = w_tgt_cmd;
                        w_period_d = w_step;
                        if (w_step == w_tgt_cmd) begin
                            w_state_d = StRun;
                        end else if (w_step > w_tgt_cmd) begin
                            w_state_d = StAccel;
                        end else begin
                            w_state_d = StDecel;
                        end
                    end
                end
                StStop: begin
                    w_target_d = PERIOD_SLOW;
                    if (stepDoneI) begin
                        w_period_d = w_stop_step;
                        if (w_stop_step == PERIOD_SLOW) begin
                            w_state_d = StIdle;
                        end
                    end
                end
                default: begin
                    w_state_d  = StIdle;
                    w_period_d = PERIOD_SLOW;
                    w_target_d = PERIOD_SLOW;
                end
            endcase
        end
    end

    // Run enable rises one cycle after leaving IDLE but drops together with it.
    assign w_m3start_d = (r_state != StIdle) && (w_state_d != StIdle);

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            r_state   <= StIdle;
            r_period  <= PERIOD_SLOW;
            r_target  <= PERIOD_SLOW;
            r_m3start <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_period  <= w_period_d;
            r_target  <= w_target_d;
            r_m3start <= w_m3start_d;
        end
    end

    assign m3startO = r_m3start;
    assign periodO  = r_period;
    assign stateO   = r_state;
    assign busyO    = (r_state != StIdle);
    assign faultO   = w_fault;

endmodule
